div_result_buffer: RTL and testbench

- Sits directly downstream of the pipelined signed divider.
- Captures each result from the divider's fixed-latency, non-stallable output (data_valid, quotient, div_by_zero) into a small FIFO.
- Presents results to the consumer over a valid/ready handshake.
- Issues credit (issue_ok) back to the operand source, so no more divides are in flight than the FIFO can absorb and results are never dropped.

---
 rtl/div_result_buffer.sv | 83 ++++++++
 tb/tb_div_result_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/div_result_buffer.sv
// div_result_buffer: credit-tracked result FIFO behind a fixed-latency, non-stallable divider
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   div_start                a divide is issued this cycle
//   issue_ok                 upstream may issue a divide this cycle
//   div_valid/div_quotient/div_dbz   divider result strobe, quotient, divide-by-zero flag
//   out_valid/out_ready      head-of-FIFO handshake to the consumer
//   out_quotient/out_dbz     head entry
//   level                    entries currently stored
//   proto_err                sticky protocol/overflow error
module div_result_buffer #(
    parameter int               WIDTH    = 4,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] DBZ_FILL = 4'b0111
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       div_start,
    output logic                       issue_ok,
    input  logic                       div_valid,
    input  logic [WIDTH-1:0]           div_quotient,
    input  logic                       div_dbz,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_quotient,
    output logic                       out_dbz,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       proto_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH:0]  mem_q [DEPTH];
    logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]   count_q, count_d, infl_q, infl_d;
    logic            err_q, err_d;
    logic            full, pop, wr_en, ovf, start_ovf, valid_unf;
    logic [CW:0]     committed;

    assign out_valid    = count_q != '0;
    assign out_quotient = mem_q[rd_q][WIDTH-1:0];
    assign out_dbz      = mem_q[rd_q][WIDTH];
    assign level        = count_q;
    assign proto_err    = err_q;
    // Credit covers both stored results and results still inside the divider.
    assign committed    = {1'b0, count_q} + {1'b0, infl_q};
    assign issue_ok     = committed < {1'b0, FULL};

    always_comb begin
        full      = count_q == FULL;
        pop       = out_valid && out_ready;
        // When full, a push is only accepted if the head is leaving this cycle.
        wr_en     = div_valid && (!full || pop);
        ovf       = div_valid && full && !pop;
        start_ovf = div_start && !issue_ok;
        valid_unf = div_valid && !div_start && infl_q == '0;
        rd_d      = pop ? rd_q + AW'(1) : rd_q;
        wr_d      = wr_en ? wr_q + AW'(1) : wr_q;
        count_d   = count_q + CW'(wr_en) - CW'(pop);
        infl_d    = (div_start && !div_valid) ? ((infl_q == FULL) ? infl_q : infl_q + CW'(1)) :
                    (div_valid && !div_start && infl_q != '0) ? infl_q - CW'(1) : infl_q;
        err_d     = err_q | ovf | start_ovf | valid_unf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            infl_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (wr_en) mem_q[wr_q] <= {div_dbz, div_dbz ? DBZ_FILL : div_quotient};
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            infl_q  <= infl_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_div_result_buffer.sv
// tb_div_result_buffer: randomized and directed checks of div_result_buffer against a queue model
module tb_div_result_buffer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       div_start = 1'b0;
    logic       issue_ok;
    logic       div_valid = 1'b0;
    logic [3:0] div_quotient = 4'h0;
    logic       div_dbz = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_quotient;
    logic       out_dbz;
    logic [2:0] level;
    logic       proto_err;

    int n_cmp = 0;
    int n_fail = 0;

    logic [4:0] mq[$];
    int         infl;
    bit         merr;

    div_result_buffer dut (
        .clk(clk), .rst(rst), .div_start(div_start), .issue_ok(issue_ok),
        .div_valid(div_valid), .div_quotient(div_quotient), .div_dbz(div_dbz),
        .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient),
        .out_dbz(out_dbz), .level(level), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // {out_valid, quotient, dbz, level, issue_ok, proto_err}; head fields only meaningful when valid
    function automatic logic [10:0] exp_vec();
        logic [4:0] h;
        h = (mq.size() != 0) ? mq[0] : 5'h0;
        return {mq.size() != 0, h[3:0], h[4], 3'(mq.size()), (mq.size() + infl) < 4, merr};
    endfunction

    function automatic logic [10:0] obs_vec();
        return {out_valid, out_valid ? out_quotient : 4'h0, out_valid & out_dbz, level, issue_ok, proto_err};
    endfunction

    task automatic cycle(input bit s, input bit v, input logic [3:0] qv, input bit d, input bit r);
        bit pop;
        div_start = s; div_valid = v; div_quotient = qv; div_dbz = d; out_ready = r;
        pop = mq.size() != 0 && r;
        if (s && (mq.size() + infl) >= 4) merr = 1;
        if (v && !s && infl == 0) merr = 1;
        if (v && mq.size() == 4 && !pop) merr = 1;
        if (pop) void'(mq.pop_front());
        if (v && mq.size() < 4) mq.push_back({d, d ? 4'h7 : qv});
        if (s && !v) infl = (infl < 4) ? infl + 1 : 4;
        else if (v && !s && infl > 0) infl = infl - 1;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        div_start = 0; div_valid = 0; div_dbz = 0; div_quotient = 0; out_ready = 0;
        #2 rst = 1;
        @(posedge clk); #1 rst = 0;
        mq.delete(); infl = 0; merr = 0;
    endtask

    task automatic fill4();
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 4'(i + 1), 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (obs_vec() !== 11'b0_0000_0_000_1_0) begin n_fail++; $display("FAIL reset_initial obs=%h exp=%h", obs_vec(), 11'b0_0000_0_000_1_0); end
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 4'($urandom_range(1, 15)), 0, 0);
        n_cmp++;
        if (obs_vec() !== exp_vec() || level !== 3'd3) begin n_fail++; $display("FAIL reset_prefill obs=%h exp=%h", obs_vec(), exp_vec()); end
        #3 rst = 1;
        #1;
        n_cmp++;
        if ({out_valid, level, issue_ok, proto_err, out_quotient, out_dbz} !== {1'b0, 3'd0, 1'b1, 1'b0, 4'h0, 1'b0}) begin
            n_fail++; $display("FAIL reset_async v=%b lvl=%0d ok=%b err=%b q=%h dbz=%b", out_valid, level, issue_ok, proto_err, out_quotient, out_dbz);
        end
        @(posedge clk); #1 rst = 0;
        mq.delete(); infl = 0; merr = 0;
        cycle(0, 0, 0, 0, 1);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL reset_after obs=%h exp=%h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_single();
        do_reset();
        cycle(1, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            cycle(0, 0, 0, 0, 1);
            n_cmp++;
            if (obs_vec() !== exp_vec() || issue_ok !== 1'b1) begin n_fail++; $display("FAIL single_wait obs=%h exp=%h", obs_vec(), exp_vec()); end
        end
        cycle(0, 1, 4'h3, 0, 1);
        n_cmp++;
        if ({out_valid, out_quotient, out_dbz} !== {1'b1, 4'h3, 1'b0} || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL single_result v=%b q=%h obs=%h exp=%h", out_valid, out_quotient, obs_vec(), exp_vec());
        end
        cycle(0, 0, 0, 0, 1);
        n_cmp++;
        if (level !== 3'd0 || issue_ok !== 1'b1 || obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL single_drain level=%0d ok=%b", level, issue_ok); end
    endtask

    task automatic test_credit();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);
        n_cmp++;
        if (issue_ok !== 1'b0 || obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL credit_block ok=%b exp=0", issue_ok); end
        for (int i = 0; i < 4; i++) cycle(0, 1, 4'(i + 1), 0, 0);
        n_cmp++;
        if (level !== 3'd4 || issue_ok !== 1'b0 || proto_err !== 1'b0) begin n_fail++; $display("FAIL credit_full level=%0d ok=%b err=%b", level, issue_ok, proto_err); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_quotient !== 4'(i + 1) || out_valid !== 1'b1) begin n_fail++; $display("FAIL credit_order q=%h exp=%h", out_quotient, 4'(i + 1)); end
            cycle(0, 0, 0, 0, 1);
            if (i == 0) begin
                n_cmp++;
                if (issue_ok !== 1'b1 || level !== 3'd3) begin n_fail++; $display("FAIL credit_release ok=%b level=%0d", issue_ok, level); end
            end
        end
    endtask

    task automatic test_dbz();
        do_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 4'h5, 1, 0);
        cycle(0, 1, 4'h2, 0, 0);
        n_cmp++;
        if ({out_dbz, out_quotient} !== {1'b1, 4'h7}) begin n_fail++; $display("FAIL dbz_fill dbz=%b q=%h exp 1/7", out_dbz, out_quotient); end
        cycle(0, 0, 0, 0, 1);
        n_cmp++;
        if ({out_valid, out_dbz, out_quotient} !== {1'b1, 1'b0, 4'h2} || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL dbz_next dbz=%b q=%h exp 0/2", out_dbz, out_quotient);
        end
    endtask

    task automatic test_full();
        do_reset();
        fill4();
        cycle(0, 1, 4'h9, 0, 0);
        n_cmp++;
        if ({proto_err, level, out_quotient} !== {1'b1, 3'd4, 4'h1} || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL full_overflow err=%b level=%0d q=%h", proto_err, level, out_quotient);
        end
        do_reset();
        fill4();
        cycle(0, 1, 4'h9, 0, 1);
        n_cmp++;
        if (level !== 3'd4 || obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL full_pushpop level=%0d obs=%h exp=%h", level, obs_vec(), exp_vec()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_quotient !== ((i == 3) ? 4'h9 : 4'(i + 2))) begin n_fail++; $display("FAIL full_order q=%h idx=%0d", out_quotient, i); end
            cycle(0, 0, 0, 0, 1);
        end
    endtask

    task automatic test_protocol();
        do_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 4'hA, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        n_cmp++;
        if ({issue_ok, proto_err, level} !== {1'b0, 1'b0, 3'd1} || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL proto_same_cycle ok=%b err=%b level=%0d", issue_ok, proto_err, level);
        end
        cycle(1, 0, 0, 0, 0);
        n_cmp++;
        if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_start_blocked err=%b exp=1", proto_err); end
        do_reset();
        cycle(0, 1, 4'h6, 0, 0);
        n_cmp++;
        if ({proto_err, level, out_quotient} !== {1'b1, 3'd1, 4'h6} || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL proto_underflow err=%b level=%0d q=%h", proto_err, level, out_quotient);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit s, v;
            s = $urandom_range(0, 3) == 0 && ((mq.size() + infl) < 4 || $urandom_range(0, 15) == 0);
            v = (infl > 0 && $urandom_range(0, 1) == 1) || $urandom_range(0, 31) == 0;
            cycle(s, v, 4'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs_vec(), exp_vec()); end
            if (i % 100 == 99) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_credit();
        test_dbz();
        test_full();
        test_protocol();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
